// File: rtl/basys_input_reader.sv
// basys_input_reader: synchronized, debounced Basys switches/buttons exposed as four
// read-only memory-mapped registers with sticky press events and a saturating press count.
module basys_input_reader #(
  parameter int          N_SW            = 16,
  parameter int          N_BTN           = 4,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  sw,
  input  logic [N_BTN-1:0] btn,
  input  logic [31:0]      Adr,
  input  logic             RdEn,
  output logic             Hit,
  output logic [31:0]      ReadData,
  output logic             irq
);
  localparam int N  = N_SW + N_BTN;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [N-1:0]     s1, s2, stable;
  logic [N_SW-1:0]  sw_st;
  logic [N_BTN-1:0] btn_st, btn_q, rise, ev, ev_clr, ev_next;
  logic [15:0]      presses;
  logic [16:0]      sum;
  logic [2:0]       pop;
  logic [1:0]       off;
  logic             rd;
  logic [31:0]      sel;
  logic             unused_adr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {btn, sw};
      s2 <= s1;
    end
  for (genvar i = 0; i < N; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic          stb;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        cnt <= '0;
        stb <= 1'b0;
      end else if (s2[i] == stb) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stb <= s2[i];
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    assign stable[i] = stb;
  end
  assign sw_st      = stable[N_SW-1:0];
  assign btn_st     = stable[N-1:N_SW];
  assign rise       = btn_st & ~btn_q;
  assign Hit        = Adr[31:4] == BASE_ADDR[31:4];
  assign off        = Adr[3:2];
  assign rd         = RdEn & Hit;
  assign unused_adr = ^Adr[1:0];
  // A clearing read drops only the bits it returns; a press in the same cycle wins.
  assign ev_clr  = (rd && off == 2'd2) ? ev : '0;
  assign ev_next = (ev & ~ev_clr) | rise;
  always_comb begin
    pop = '0;
    for (int k = 0; k < N_BTN; k++) pop = pop + 3'(rise[k]);
  end
  assign sum = {1'b0, presses} + 17'(pop);
  assign sel = off == 2'd0 ? 32'(sw_st) :
               off == 2'd1 ? 32'(btn_st) :
               off == 2'd2 ? 32'(ev) : {16'b0, presses};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      btn_q    <= '0;
      ev       <= '0;
      presses  <= '0;
      ReadData <= '0;
      irq      <= 1'b0;
    end else begin
      btn_q <= btn_st;
      ev    <= ev_next;
      irq   <= |ev_next;
      if (|rise) presses <= sum[16] ? 16'hFFFF : sum[15:0];
      if (rd) ReadData <= sel;
    end
endmodule

// File: doc/basys_input_reader.md
Name: basys_input_reader

Overview:
- Input-side counterpart of the board seven-segment display path: samples Basys switches and push-buttons and makes them readable by the pipelined processor.
- Synchronizes, debounces and edge-detects the raw pins.
- Exposes four read-only, memory-mapped registers on a registered read port in the processor's data-memory address space.
- The top level muxes ReadData into the processor's data-memory read path when Hit=1.

Parameters:
- N_SW, 16, number of switch inputs (1..16).
- N_BTN, 4, number of push-button inputs (1..4).
- DEBOUNCE_CYCLES, 50000, consecutive stable clocks required before an input change is accepted (≥2).
- BASE_ADDR, 32'h0000_0100, byte base of the 16-byte register window; must be 16-byte aligned.

Ports:
- clk  in  1  processor-domain clock (same clock as the processor).
- rst  in  1  asynchronous, active-low reset.
- sw  in  N_SW  raw switch pins, asynchronous to clk.
- btn  in  N_BTN  raw button pins, asynchronous to clk, 1 = pressed.
- Adr  in  32  processor data address.
- RdEn  in  1  read strobe, sampled with Adr.
- Hit  out  1  combinational: Adr in [BASE_ADDR, BASE_ADDR+15].
- ReadData  out  32  registered read data.
- irq  out  1  registered; high while any EVENT bit is set.

Behaviour:
- Reset (rst=0, async): ReadData=0, irq=0. Sync flops, stable values, debounce counters, EVENT and PRESSES all clear to 0.
- Synchronizer: each sw/btn bit passes through 2 flops.
- Debounce, per bit:
  - Counter is cleared whenever the synced value equals the stable value.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and synced still differs, stable<=synced and the counter clears.
  - A clean edge held steady reaches stable DEBOUNCE_CYCLES+2 clocks after the pin changes.
  - A glitch shorter than DEBOUNCE_CYCLES clocks never reaches stable.
- Press detect: rise[i] = btn_stable[i] & ~btn_stable_q[i], a one-cycle pulse. Releases generate nothing.
- Register map (offset = Adr[3:2]; Adr[1:0] ignored):
  - 0x0 SW: {zero-extend, sw_stable}.
  - 0x4 BTN: {zero-extend, btn_stable}.
  - 0x8 EVENT: sticky press flags, read-to-clear.
  - 0xC PRESSES: {16'b0, 16-bit saturating count of accepted presses}.
- Read timing:
  - On a clock edge with RdEn=1 and Hit=1, ReadData latches the selected register; data is valid the next cycle (1-cycle latency).
  - With RdEn=0 or Hit=0, ReadData holds its value.
- EVENT read-to-clear:
  - A read at offset 0x8 returns the pre-clear value.
  - Only the bits returned are cleared.
  - If rise[i] occurs in the same cycle as the clearing read, bit i stays set (set wins) and ReadData shows the old value of bit i.
- PRESSES:
  - Adds popcount(rise) each cycle, so simultaneous presses each count.
  - Saturates at 16'hFFFF; never wraps.
  - Cleared only by reset.
- irq <= |EVENT_next, registered.
- Reset mid-debounce: pending changes are discarded. After release the stable value is re-acquired from 0 through full debounce; an input already held high produces a press after DEBOUNCE_CYCLES+2 clocks.
- Unused upper bits (above N_SW / N_BTN) read 0.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Reset:
  - Stimulus: hold rst=0 with sw=16'hFFFF and btn=4'hF, then release and read SW one clock later.
  - Required: ReadData=0, irq=0. SW reads 0 until 6 clocks after release, then reads 32'h0000_FFFF.
- Glitch rejection: btn[0] high for 3 clocks, then low -> BTN reads 0, EVENT reads 0, PRESSES reads 0, irq stays 0.
- Clean press:
  - Stimulus: btn[2] high and held.
  - Required: BTN=4'b0100 and irq=1 from 7 clocks after the pin change.
  - Read EVENT -> returns 32'h4; a second read returns 0; irq drops the cycle after the first read.
- Set/clear collision:
  - Stimulus: EVENT=4'h1; time a btn[3] rise to coincide with the EVENT read.
  - Required: read returns 32'h1; the next read returns 32'h8.
- Saturation and simultaneity:
  - Stimulus: force PRESSES to 16'hFFFE via 1-step presses, then press btn[0] and btn[1] together.
  - Required: PRESSES=16'hFFFF; further presses leave it 16'hFFFF.
- Address decode:
  - Stimulus: Adr=BASE_ADDR+0x10 with RdEn=1.
  - Required: Hit=0 and ReadData unchanged. Adr=BASE_ADDR+0x6 reads the BTN register.
